// File: rtl/mii_tx_framer.sv
// Byte-stream to MII nibble framer: preamble/SFD, data, zero padding, CRC-32 FCS, inter-frame gap.
// State and counters describe the nibble currently on the wire; the next nibble is computed and registered.
module mii_tx_framer #(
   parameter int APPEND_FCS  = 1,
   parameter int MIN_FRAME   = 60,
   parameter int IFG_NIBBLES = 24
) (
   input  logic       ACLK,
   input  logic       ARESET,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   input  logic       s_axis_tlast,
   output logic       s_axis_tready,
   output logic       mii_tx_en,
   output logic [3:0] mii_txd,
   output logic       busy,
   output logic       underflow
);

   typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DROP} state_t;

   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
   localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   logic        hi, hi_n;
   logic [3:0]  data_hi, data_hi_n;
   logic        last_q, last_n;
   logic [15:0] byte_cnt, byte_cnt_n, byte_cnt_inc;
   logic [31:0] crc, crc_n, crc_inv;
   logic        tx_en_n, underflow_n, end_bytes;
   logic [3:0]  txd_n;
   logic [2:0]  fidx;

   assign busy         = (state != IDLE);
   assign byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
   assign crc_inv      = ~crc;
   assign fidx         = cnt[2:0] + 3'd1;

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      hi_n          = hi;
      data_hi_n     = data_hi;
      last_n        = last_q;
      byte_cnt_n    = byte_cnt;
      crc_n         = crc;
      tx_en_n       = 1'b0;
      txd_n         = 4'h0;
      underflow_n   = 1'b0;
      s_axis_tready = 1'b0;
      end_bytes     = 1'b0;
      case (state)
         IDLE: begin
            if (s_axis_tvalid) begin
               state_n = PREAMBLE;
               cnt_n   = '0;
               tx_en_n = 1'b1;
               txd_n   = 4'h5;
            end
         end
         PREAMBLE: begin
            crc_n      = CRC_INIT;
            byte_cnt_n = '0;
            if (cnt != 16'd15) begin
               cnt_n   = cnt + 16'd1;
               tx_en_n = 1'b1;
               txd_n   = (cnt == 16'd14) ? 4'hD : 4'h5;
            end else begin
               s_axis_tready = 1'b1;
            end
         end
         DATA: begin
            if (!hi) begin
               hi_n    = 1'b1;
               tx_en_n = 1'b1;
               txd_n   = data_hi;
            end else if (!last_q) begin
               s_axis_tready = 1'b1;
            end else begin
               end_bytes = 1'b1;
            end
         end
         PAD: begin
            if (!hi) begin
               hi_n    = 1'b1;
               tx_en_n = 1'b1;
            end else begin
               end_bytes = 1'b1;
            end
         end
         FCS: begin
            if (cnt != 16'd7) begin
               cnt_n   = cnt + 16'd1;
               tx_en_n = 1'b1;
               txd_n   = crc_inv[{fidx, 2'b00} +: 4];
            end else begin
               state_n = IFG;
               cnt_n   = '0;
            end
         end
         IFG: begin
            // A frame already waiting starts straight after the last idle nibble, so the gap is exact.
            if (cnt < IFG_LAST) begin
               cnt_n = cnt + 16'd1;
            end else if (s_axis_tvalid) begin
               state_n = PREAMBLE;
               cnt_n   = '0;
               tx_en_n = 1'b1;
               txd_n   = 4'h5;
            end else begin
               state_n = IDLE;
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_n = IFG;
               cnt_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase

      if (s_axis_tready && state != DROP) begin
         if (s_axis_tvalid) begin
            state_n    = DATA;
            hi_n       = 1'b0;
            data_hi_n  = s_axis_tdata[7:4];
            last_n     = s_axis_tlast;
            byte_cnt_n = byte_cnt_inc;
            crc_n      = crc_byte(crc, s_axis_tdata);
            tx_en_n    = 1'b1;
            txd_n      = s_axis_tdata[3:0];
         end else begin
            state_n     = DROP;
            underflow_n = 1'b1;
         end
      end

      if (end_bytes) begin
         if (byte_cnt < MIN_LEN) begin
            state_n    = PAD;
            hi_n       = 1'b0;
            byte_cnt_n = byte_cnt_inc;
            crc_n      = crc_byte(crc, 8'h00);
            tx_en_n    = 1'b1;
         end else if (APPEND_FCS != 0) begin
            state_n = FCS;
            cnt_n   = '0;
            tx_en_n = 1'b1;
            txd_n   = crc_inv[3:0];
         end else begin
            state_n = IFG;
            cnt_n   = '0;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= IDLE;
         cnt       <= '0;
         hi        <= 1'b0;
         data_hi   <= '0;
         last_q    <= 1'b0;
         byte_cnt  <= '0;
         crc       <= '0;
         mii_tx_en <= 1'b0;
         mii_txd   <= '0;
         underflow <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hi        <= hi_n;
         data_hi   <= data_hi_n;
         last_q    <= last_n;
         byte_cnt  <= byte_cnt_n;
         crc       <= crc_n;
         mii_tx_en <= tx_en_n;
         mii_txd   <= txd_n;
         underflow <= underflow_n;
      end
   end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Drives three framer configurations and checks the captured MII frames against a byte-level reference model.
module tb_mii_tx_framer;

   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic [7:0] tdata [3];
   logic       tvalid [3];
   logic       tlast [3];
   logic       tready [3];
   logic       txen [3];
   logic [3:0] txd [3];
   logic       busy [3];
   logic       uf [3];

   always #5 clk = ~clk;

   mii_tx_framer #(.APPEND_FCS(1), .MIN_FRAME(60), .IFG_NIBBLES(24)) u_dut0 (
      .ACLK(clk), .ARESET(arst), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
      .s_axis_tlast(tlast[0]), .s_axis_tready(tready[0]), .mii_tx_en(txen[0]),
      .mii_txd(txd[0]), .busy(busy[0]), .underflow(uf[0]));
   mii_tx_framer #(.APPEND_FCS(1), .MIN_FRAME(0), .IFG_NIBBLES(8)) u_dut1 (
      .ACLK(clk), .ARESET(arst), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
      .s_axis_tlast(tlast[1]), .s_axis_tready(tready[1]), .mii_tx_en(txen[1]),
      .mii_txd(txd[1]), .busy(busy[1]), .underflow(uf[1]));
   mii_tx_framer #(.APPEND_FCS(0), .MIN_FRAME(0), .IFG_NIBBLES(5)) u_dut2 (
      .ACLK(clk), .ARESET(arst), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
      .s_axis_tlast(tlast[2]), .s_axis_tready(tready[2]), .mii_tx_en(txen[2]),
      .mii_txd(txd[2]), .busy(busy[2]), .underflow(uf[2]));

   function automatic int fcs_of(input int k); return (k == 2) ? 0 : 1; endfunction
   function automatic int min_of(input int k); return (k == 0) ? 60 : 0; endfunction

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Wire monitor: one captured frame per tx_en burst, idle length before each burst.
   logic [3:0] cur [3][$];
   logic [3:0] last_frame [3][$];
   int nframes [3] = '{0, 0, 0};
   int idle_cnt [3] = '{0, 0, 0};
   int last_gap [3] = '{0, 0, 0};
   int uf_cnt [3] = '{0, 0, 0};
   int viol [3] = '{0, 0, 0};
   logic prev_en [3] = '{1'b0, 1'b0, 1'b0};

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (txen[k] === 1'b1) begin
            if (!prev_en[k]) last_gap[k] = idle_cnt[k];
            cur[k].push_back(txd[k]);
         end else begin
            if (prev_en[k]) begin
               last_frame[k] = cur[k];
               cur[k].delete();
               nframes[k]++;
               idle_cnt[k] = 0;
            end
            idle_cnt[k]++;
            if (txd[k] !== 4'h0) viol[k]++;
         end
         if (uf[k] === 1'b1) uf_cnt[k]++;
         prev_en[k] = (txen[k] === 1'b1);
      end
   end

   function automatic logic [31:0] crc32_ref(input logic [7:0] d[$]);
      logic [31:0] c;
      logic fb;
      c = 32'hFFFF_FFFF;
      foreach (d[i]) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ d[i][j];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      return ~c;
   endfunction

   // Expected wire nibbles for one frame; tail=0 models a truncated frame (no pad, no FCS).
   task automatic model(input logic [7:0] b[$], input int fcs, input int minf, input bit tail,
                        output logic [3:0] e[$]);
      logic [7:0] d[$];
      logic [31:0] c;
      e = {};
      repeat (15) e.push_back(4'h5);
      e.push_back(4'hD);
      d = b;
      if (tail) while (d.size() < minf) d.push_back(8'h00);
      foreach (d[i]) begin
         e.push_back(d[i][3:0]);
         e.push_back(d[i][7:4]);
      end
      if (tail && fcs != 0) begin
         c = crc32_ref(d);
         for (int j = 0; j < 8; j++) e.push_back(c[4*j +: 4]);
      end
   endtask

   logic [7:0] sb[$];
   logic       sl[$];

   task automatic add_frame(input logic [7:0] b[$]);
      foreach (b[i]) begin
         sb.push_back(b[i]);
         sl.push_back(i == b.size() - 1);
      end
   endtask

   task automatic send_stream(input int k, input int stall_at, input int stall_len);
      int i, cyc;
      logic hs;
      i = 0;
      cyc = 0;
      tvalid[k] = 1'b1;
      tdata[k]  = sb[0];
      tlast[k]  = sl[0];
      while (i < sb.size() && cyc < 4000) begin
         @(negedge clk);
         hs = tready[k];
         @(posedge clk);
         #1;
         cyc++;
         if (hs) begin
            i++;
            if (i == stall_at) begin
               tvalid[k] = 1'b0;
               repeat (stall_len) @(posedge clk);
               #1;
            end
            if (i < sb.size()) begin
               tvalid[k] = 1'b1;
               tdata[k]  = sb[i];
               tlast[k]  = sl[i];
            end else begin
               tvalid[k] = 1'b0;
               tlast[k]  = 1'b0;
            end
         end
      end
      tvalid[k] = 1'b0;
      check("send_bytes_accepted", i, sb.size());
   endtask

   task automatic wait_frames(input int k, input int target, input string name);
      int c;
      c = 0;
      while (nframes[k] < target && c < 5000) begin
         @(negedge clk);
         c++;
      end
      check({name, "_frame_done"}, nframes[k] >= target, 1);
   endtask

   task automatic cmp_frame(input string name, input int k, input logic [7:0] b[$], input bit tail);
      logic [3:0] e[$];
      int mis;
      model(b, fcs_of(k), min_of(k), tail, e);
      check({name, "_len"}, last_frame[k].size(), e.size());
      mis = -1;
      for (int i = 0; i < e.size() && i < last_frame[k].size(); i++)
         if (mis < 0 && last_frame[k][i] !== e[i]) mis = i;
      check({name, "_first_bad_nibble"}, mis, -1);
   endtask

   task automatic run_frame(input string name, input int k, input logic [7:0] b[$]);
      int base;
      sb.delete();
      sl.delete();
      add_frame(b);
      base = nframes[k];
      send_stream(k, -1, 0);
      wait_frames(k, base + 1, name);
      cmp_frame(name, k, b, 1'b1);
   endtask

   function automatic logic [31:0] fcs_word(input int k);
      logic [31:0] w;
      int sz;
      w = '0;
      sz = last_frame[k].size();
      if (sz >= 8) for (int j = 0; j < 8; j++) w[4*j +: 4] = last_frame[k][sz - 8 + j];
      return w;
   endfunction

   typedef struct {
      int         inst;
      int         n;
      logic [7:0] first;
      logic [7:0] step;
      int         exp_len;
      bit         chk_fcs;
      logic [31:0] exp_fcs;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [7:0] fb[$];
      logic [7:0] fa[$];
      logic [7:0] v;
      int base, ub, c, k;

      tbl[0] = '{1,  9, 8'h31, 8'h01,  42, 1'b1, 32'hCBF4_3926};
      tbl[1] = '{0,  1, 8'hAB, 8'h00, 144, 1'b0, 32'h0};
      tbl[2] = '{2,  2, 8'h12, 8'h22,  20, 1'b0, 32'h0};
      tbl[3] = '{0, 60, 8'h00, 8'h01, 144, 1'b0, 32'h0};
      tbl[4] = '{0, 61, 8'h07, 8'h0D, 146, 1'b0, 32'h0};
      tbl[5] = '{1,  1, 8'hFF, 8'h00,  26, 1'b0, 32'h0};
      tbl[6] = '{1, 64, 8'hC3, 8'h35, 152, 1'b0, 32'h0};

      for (int i = 0; i < 3; i++) begin
         tdata[i]  = 8'h00;
         tvalid[i] = 1'b0;
         tlast[i]  = 1'b0;
      end
      tvalid[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         check($sformatf("reset_outputs%0d", i),
               {txen[i], txd[i], tready[i], busy[i], uf[i]}, 8'h00);
      tvalid[0] = 1'b0;
      @(posedge clk);
      #1 arst = 1'b0;

      foreach (tbl[t]) begin
         fb = {};
         v = tbl[t].first;
         for (int i = 0; i < tbl[t].n; i++) begin
            fb.push_back(v);
            v = v + tbl[t].step;
         end
         run_frame($sformatf("vec%0d", t), tbl[t].inst, fb);
         check($sformatf("vec%0d_txen_cycles", t), last_frame[tbl[t].inst].size(), tbl[t].exp_len);
         if (tbl[t].chk_fcs)
            check($sformatf("vec%0d_fcs", t), fcs_word(tbl[t].inst), tbl[t].exp_fcs);
      end

      // Back-to-back 64-byte frames with tvalid held high.
      fa = {};
      fb = {};
      for (int i = 0; i < 64; i++) begin
         fa.push_back(8'($urandom));
         fb.push_back(8'($urandom));
      end
      sb.delete();
      sl.delete();
      add_frame(fa);
      add_frame(fb);
      base = nframes[0];
      send_stream(0, -1, 0);
      wait_frames(0, base + 1, "b2b_a");
      cmp_frame("b2b_a", 0, fa, 1'b1);
      wait_frames(0, base + 2, "b2b_b");
      cmp_frame("b2b_b", 0, fb, 1'b1);
      check("b2b_gap", last_gap[0], 24);

      // Upstream stalls after byte 5 of 20.
      fa = {};
      for (int i = 0; i < 20; i++) fa.push_back(8'(8'h40 + i));
      sb.delete();
      sl.delete();
      add_frame(fa);
      ub = uf_cnt[0];
      base = nframes[0];
      send_stream(0, 5, 3);
      wait_frames(0, base + 1, "uflow");
      fb = fa[0:4];
      cmp_frame("uflow_trunc", 0, fb, 1'b0);
      check("uflow_pulses", uf_cnt[0] - ub, 1);
      fb = {};
      for (int i = 0; i < 10; i++) fb.push_back(8'(8'hA0 ^ i));
      run_frame("after_uflow", 0, fb);

      // Reset while the FCS is on the wire.
      fa = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      sb.delete();
      sl.delete();
      add_frame(fa);
      base = nframes[1];
      ub = uf_cnt[1];
      send_stream(1, -1, 0);
      c = 0;
      while (cur[1].size() != 36 && c < 500) begin
         @(negedge clk);
         c++;
      end
      check("rst_fcs_reached", cur[1].size(), 36);
      arst = 1'b1;
      @(negedge clk);
      check("rst_txen", txen[1], 1'b0);
      check("rst_busy", busy[1], 1'b0);
      arst = 1'b0;
      @(negedge clk);
      check("rst_no_uflow", uf_cnt[1] - ub, 0);
      check("rst_truncated", nframes[1] == base + 1 && last_frame[1].size() < 42, 1);
      run_frame("after_rst", 1, fa);
      check("after_rst_fcs", fcs_word(1), 32'hCBF4_3926);

      for (int it = 0; it < 12; it++) begin
         k = $urandom_range(0, 2);
         fb = {};
         c = $urandom_range(1, 70);
         for (int i = 0; i < c; i++) fb.push_back(8'($urandom));
         repeat ($urandom_range(0, 30)) @(posedge clk);
         #1;
         run_frame($sformatf("rnd%0d_inst%0d", it, k), k, fb);
      end

      repeat (40) @(negedge clk);
      for (int i = 0; i < 3; i++)
         check($sformatf("txd_zero_when_idle%0d", i), viol[i], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
